// File: rtl/imem_boot_ctrl_pkg.sv
// Shared constants for the instruction-memory boot loader and fetch sequencer.
// Holds the FSM encoding, the word geometry and the fault-return instruction.
package imem_boot_pkg;

    localparam logic [1:0] BOOT   = 2'd0;
    localparam logic [1:0] COMMIT = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;

    localparam int BYTES_PER_WORD = 4;

    // addi x0,x0,0 -- harmless filler returned on a faulting fetch
    localparam logic [31:0] NOP_INST = 32'h00000013;

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Loader, fetch and memory-port signals of imem_boot_ctrl bundled as one interface.
// The master view belongs to the controller; the slave view to its environment.
interface imem_boot_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              ld_valid;
    logic [7:0]        ld_byte;
    logic              ld_last;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_words;
    logic              ld_err;
    logic              core_run;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [31:0]       fetch_inst;
    logic              fetch_err;
    logic              mem_store;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        input  ld_valid, ld_byte, ld_last, fetch_req, fetch_addr, mem_rdata,
        output ld_ready, ld_words, ld_err, core_run, fetch_valid, fetch_inst,
               fetch_err, mem_store, mem_addr, mem_wdata
    );

    modport slave (
        output ld_valid, ld_byte, ld_last, fetch_req, fetch_addr, mem_rdata,
        input  ld_ready, ld_words, ld_err, core_run, fetch_valid, fetch_inst,
               fetch_err, mem_store, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_boot_ctrl_byte_packer.sv
// Packs accepted loader bytes little-endian into a 32-bit word buffer.
// Unfilled lanes stay zero because the buffer is cleared after every commit.
module byte_packer
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        last_in,
    output logic [31:0] word,
    output logic        word_done,
    output logic        word_last
);

    logic [1:0] byte_cnt;

    assign word_done = accept && ((byte_cnt == 2'(BYTES_PER_WORD - 1)) || last_in);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_cnt  <= 2'd0;
            word      <= 32'd0;
            word_last <= 1'b0;
        end else if (accept) begin
            word[{byte_cnt, 3'b000} +: 8] <= byte_in;
            byte_cnt                      <= byte_cnt + 2'd1;
            if (last_in) begin
                word_last <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader and fetch sequencer: sole master of the instruction memory port.
// Packs the boot image into words, commits them, then serves 1-cycle fetches.
module imem_boot_ctrl
    import imem_boot_pkg::*;
#(
    parameter int          DEPTH  = 32,
    parameter int          ADDR_W = 32,
    parameter logic [31:0] NOP    = NOP_INST
) (
    input  logic             clk,
    input  logic             rst,
    imem_boot_ctrl_if.master bus
);

    // Highest byte address at which a whole word still fits in memory
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - BYTES_PER_WORD);

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [31:0]       word;
    logic              word_done;
    logic              word_last;
    logic              accept;
    logic              fits;
    logic              fault;

    assign bus.ld_ready  = (state == BOOT) && !rst;
    assign accept        = bus.ld_valid && bus.ld_ready;
    assign fits          = (wr_ptr <= LAST_WORD);
    assign fault         = (bus.fetch_addr[1:0] != 2'b00) || (bus.fetch_addr > LAST_WORD);
    assign bus.core_run  = (state == RUN);
    assign bus.mem_addr  = (state == RUN) ? bus.fetch_addr : wr_ptr;
    assign bus.mem_wdata = word;
    assign bus.mem_store = (state == COMMIT) && fits;

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .clear     (state == COMMIT),
        .byte_in   (bus.ld_byte),
        .last_in   (bus.ld_last),
        .word      (word),
        .word_done (word_done),
        .word_last (word_last)
    );

    // An overflowing word is dropped but still ends the image if it carried ld_last
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            wr_ptr       <= '0;
            bus.ld_words <= '0;
            bus.ld_err   <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    if (word_done) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (fits) begin
                        wr_ptr       <= wr_ptr + ADDR_W'(BYTES_PER_WORD);
                        bus.ld_words <= bus.ld_words + 1'b1;
                    end else begin
                        bus.ld_err <= 1'b1;
                    end
                    state <= word_last ? RUN : BOOT;
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.fetch_valid <= 1'b0;
            bus.fetch_err   <= 1'b0;
            bus.fetch_inst  <= 32'd0;
        end else if ((state == RUN) && bus.fetch_req) begin
            bus.fetch_valid <= 1'b1;
            bus.fetch_err   <= fault;
            bus.fetch_inst  <= fault ? NOP : bus.mem_rdata;
        end else begin
            bus.fetch_valid <= 1'b0;
            bus.fetch_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: boot loads, overflow, fetches and reset mid-load.
// A small byte-addressed memory model answers the controller's memory port.
module tb_imem_boot_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;
    int   base   = 0;

    imem_boot_ctrl_if #(.ADDR_W(32)) bus ();

    imem_boot_ctrl #(
        .DEPTH  (32),
        .ADDR_W (32),
        .NOP    (32'h00000013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [0:7];
    logic [31:0] st_addr [0:63];
    logic [31:0] st_data [0:63];
    int          st_n = 0;

    assign bus.mem_rdata = (bus.mem_addr < 32) ? mem[bus.mem_addr[4:2]] : 32'hDEADBEEF;

    // Memory model plus a log of every store the controller issues
    always @(posedge clk) begin
        if (bus.mem_store) begin
            if (bus.mem_addr < 32) begin
                mem[bus.mem_addr[4:2]] <= bus.mem_wdata;
            end
            if (st_n < 64) begin
                st_addr[st_n] <= bus.mem_addr;
                st_data[st_n] <= bus.mem_wdata;
                st_n          <= st_n + 1;
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic apply_byte(input logic [7:0] b, input logic last);
        int waited = 0;
        @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        bus.ld_last  = last;
        while (bus.ld_ready !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check_output("ld_ready_wait", {31'd0, bus.ld_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.ld_valid  = 1'b0;
        bus.ld_last   = 1'b0;
        bus.fetch_req = 1'b0;
        #1;
        check_output("ld_ready_in_rst", {31'd0, bus.ld_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("rst_ld_words", bus.ld_words, 32'd0);
        check_output("rst_ld_err", {31'd0, bus.ld_err}, 32'd0);
        check_output("rst_core_run", {31'd0, bus.core_run}, 32'd0);
        check_output("rst_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
        check_output("rst_mem_store", {31'd0, bus.mem_store}, 32'd0);
        check_output("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    endtask

    initial begin
        bus.ld_valid   = 1'b0;
        bus.ld_byte    = 8'd0;
        bus.ld_last    = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 32'd0;

        do_reset();
        check_output("rst_fetch_inst", bus.fetch_inst, 32'd0);

        // Fetches while still booting are dropped
        @(negedge clk);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'd0;
        @(negedge clk);
        check_output("boot_fetch_valid_a", {31'd0, bus.fetch_valid}, 32'd0);
        @(negedge clk);
        check_output("boot_fetch_valid_b", {31'd0, bus.fetch_valid}, 32'd0);
        bus.fetch_req = 1'b0;

        // Eight bytes 01..08, last on 08
        base = st_n;
        for (int i = 1; i <= 8; i++) begin
            apply_byte(8'(i), i == 8);
        end
        check_output("t1_commit_store", {31'd0, bus.mem_store}, 32'd1);
        check_output("t1_commit_addr", bus.mem_addr, 32'd4);
        check_output("t1_commit_wdata", bus.mem_wdata, 32'h08070605);
        check_output("t1_commit_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        @(posedge clk);
        #1;
        check_output("t1_core_run", {31'd0, bus.core_run}, 32'd1);
        check_output("t1_ld_words", bus.ld_words, 32'd2);
        check_output("t1_store_count", 32'(st_n - base), 32'd2);
        check_output("t1_store0_addr", st_addr[base], 32'd0);
        check_output("t1_store0_data", st_data[base], 32'h04030201);
        check_output("t1_store1_addr", st_addr[base+1], 32'd4);

        // Five bytes AA..EE, last on EE: second word zero-padded
        do_reset();
        base = st_n;
        apply_byte(8'hAA, 1'b0);
        apply_byte(8'hBB, 1'b0);
        apply_byte(8'hCC, 1'b0);
        apply_byte(8'hDD, 1'b0);
        apply_byte(8'hEE, 1'b1);
        @(posedge clk);
        #1;
        check_output("t2_core_run", {31'd0, bus.core_run}, 32'd1);
        check_output("t2_store_count", 32'(st_n - base), 32'd2);
        check_output("t2_store0_data", st_data[base], 32'hDDCCBBAA);
        check_output("t2_store1_addr", st_addr[base+1], 32'd4);
        check_output("t2_store1_data", st_data[base+1], 32'h000000EE);

        // Reset after three bytes, then reload one full word
        do_reset();
        base = st_n;
        apply_byte(8'h99, 1'b0);
        apply_byte(8'h98, 1'b0);
        apply_byte(8'h97, 1'b0);
        do_reset();
        apply_byte(8'h11, 1'b0);
        apply_byte(8'h22, 1'b0);
        apply_byte(8'h33, 1'b0);
        apply_byte(8'h44, 1'b0);
        @(posedge clk);
        #1;
        check_output("t6_store_count", 32'(st_n - base), 32'd1);
        check_output("t6_store_addr", st_addr[base], 32'd0);
        check_output("t6_store_data", st_data[base], 32'h44332211);
        check_output("t6_ld_words", bus.ld_words, 32'd1);
        check_output("t6_core_run", {31'd0, bus.core_run}, 32'd0);
        check_output("t6_ld_ready", {31'd0, bus.ld_ready}, 32'd1);

        // 36-byte image into a 32-byte memory: ninth word suppressed
        do_reset();
        base = st_n;
        for (int i = 0; i < 36; i++) begin
            apply_byte(8'(i), i == 35);
        end
        check_output("t3_ninth_store", {31'd0, bus.mem_store}, 32'd0);
        @(posedge clk);
        #1;
        check_output("t3_store_count", 32'(st_n - base), 32'd8);
        check_output("t3_store0_data", st_data[base], 32'h03020100);
        check_output("t3_store7_addr", st_addr[base+7], 32'd28);
        check_output("t3_store7_data", st_data[base+7], 32'h1F1E1D1C);
        check_output("t3_ld_err", {31'd0, bus.ld_err}, 32'd1);
        check_output("t3_ld_words", bus.ld_words, 32'd8);
        check_output("t3_core_run", {31'd0, bus.core_run}, 32'd1);

        // Back-to-back fetches, then two faulting addresses
        @(negedge clk);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'd0;
        @(negedge clk);
        check_output("t4_f0_valid", {31'd0, bus.fetch_valid}, 32'd1);
        check_output("t4_f0_inst", bus.fetch_inst, 32'h03020100);
        check_output("t4_f0_err", {31'd0, bus.fetch_err}, 32'd0);
        bus.fetch_addr = 32'd4;
        @(negedge clk);
        check_output("t4_f1_valid", {31'd0, bus.fetch_valid}, 32'd1);
        check_output("t4_f1_inst", bus.fetch_inst, 32'h07060504);
        bus.fetch_addr = 32'd8;
        @(negedge clk);
        check_output("t4_f2_valid", {31'd0, bus.fetch_valid}, 32'd1);
        check_output("t4_f2_inst", bus.fetch_inst, 32'h0B0A0908);
        check_output("t4_f2_err", {31'd0, bus.fetch_err}, 32'd0);
        bus.fetch_addr = 32'd2;
        @(negedge clk);
        check_output("t5_misalign_valid", {31'd0, bus.fetch_valid}, 32'd1);
        check_output("t5_misalign_err", {31'd0, bus.fetch_err}, 32'd1);
        check_output("t5_misalign_inst", bus.fetch_inst, 32'h00000013);
        bus.fetch_addr = 32'd32;
        @(negedge clk);
        check_output("t5_range_err", {31'd0, bus.fetch_err}, 32'd1);
        check_output("t5_range_inst", bus.fetch_inst, 32'h00000013);
        bus.fetch_addr = 32'd4;
        @(negedge clk);
        check_output("t5_recover_err", {31'd0, bus.fetch_err}, 32'd0);
        check_output("t5_recover_inst", bus.fetch_inst, 32'h07060504);
        bus.fetch_req = 1'b0;
        @(negedge clk);
        check_output("idle_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
        check_output("idle_fetch_err", {31'd0, bus.fetch_err}, 32'd0);
        check_output("idle_fetch_hold", bus.fetch_inst, 32'h07060504);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
